// File: rtl/ac_alu.sv
// ac_alu: accumulator ALU owning the E flip-flop; single-cycle ops plus optional
// shift-add multiply (opcode A) enabled by macro AC_ALU_MUL_EN.
module ac_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             REST,
    input  logic             START,
    input  logic [3:0]       OP,
    input  logic [WIDTH-1:0] AC_IN,
    input  logic [WIDTH-1:0] DR_IN,
    output logic [WIDTH-1:0] RESULT,
    output logic             AC_LOAD,
    output logic             E,
    output logic             BUSY,
    output logic             DONE
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIN  = 2'd1
`ifdef AC_ALU_MUL_EN
        , MUL = 2'd2
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             e_q, e_d;
    logic             ld_q, ld_d;
`ifdef AC_ALU_MUL_EN
    localparam int CW = $clog2(WIDTH + 1);
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH:0]     sum;
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        e_d      = e_q;
        ld_d     = ld_q;
`ifdef AC_ALU_MUL_EN
        p_d      = p_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        sum      = '0;
`endif
        case (state_q)
            IDLE: if (START) begin
                state_d = FIN;
                ld_d    = 1'b1;
                case (OP)
                    4'h0: result_d = '0;
                    4'h1: result_d = AC_IN & DR_IN;
                    4'h2: {e_d, result_d} = {1'b0, AC_IN} + {1'b0, DR_IN};
                    4'h3: result_d = DR_IN;
                    4'h4: result_d = ~AC_IN;
                    4'h5: begin e_d = ~e_q; ld_d = 1'b0; end
                    4'h6: begin result_d = {e_q, AC_IN[WIDTH-1:1]}; e_d = AC_IN[0]; end
                    4'h7: begin result_d = {AC_IN[WIDTH-2:0], e_q}; e_d = AC_IN[WIDTH-1]; end
                    4'h8: result_d = AC_IN + WIDTH'(1);
                    4'h9: begin e_d = 1'b0; ld_d = 1'b0; end
`ifdef AC_ALU_MUL_EN
                    4'hA: begin
                        state_d = MUL;
                        p_d     = {{WIDTH{1'b0}}, DR_IN};
                        m_d     = AC_IN;
                        cnt_d   = '0;
                    end
`endif
                    default: ld_d = 1'b0;
                endcase
            end
`ifdef AC_ALU_MUL_EN
            // One idle-free finalize cycle after WIDTH iterations commits the product.
            MUL: if (cnt_q == CW'(WIDTH)) begin
                state_d  = FIN;
                result_d = p_q[WIDTH-1:0];
                e_d      = |p_q[2*WIDTH-1:WIDTH];
                ld_d     = 1'b1;
            end else begin
                sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
                p_d   = {sum, p_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge REST) begin
        if (REST) begin
            state_q  <= IDLE;
            result_q <= '0;
            e_q      <= 1'b0;
            ld_q     <= 1'b0;
`ifdef AC_ALU_MUL_EN
            p_q      <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            e_q      <= e_d;
            ld_q     <= ld_d;
`ifdef AC_ALU_MUL_EN
            p_q      <= p_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign RESULT  = result_q;
    assign E       = e_q;
    assign BUSY    = state_q != IDLE;
    assign DONE    = state_q == FIN;
    assign AC_LOAD = (state_q == FIN) && ld_q;
endmodule

// File: tb/tb_ac_alu.sv
// tb_ac_alu: random and directed checks of ac_alu against an arithmetic reference model.
module tb_ac_alu;
    localparam int W = 16;
`ifdef AC_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         REST = 1'b1;
    logic         START = 1'b0;
    logic [3:0]   OP = '0;
    logic [W-1:0] AC_IN = '0, DR_IN = '0;
    logic [W-1:0] RESULT;
    logic         AC_LOAD, E, BUSY, DONE;

    int n_chk = 0;
    int n_pass = 0;
    logic [W-1:0] model_r = '0;
    logic         model_e = 1'b0;

    ac_alu #(.WIDTH(W)) dut (
        .clk(clk), .REST(REST), .START(START), .OP(OP), .AC_IN(AC_IN), .DR_IN(DR_IN),
        .RESULT(RESULT), .AC_LOAD(AC_LOAD), .E(E), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_result"}, 32'(RESULT), 32'h0);
        check({tag, "_e"}, 32'(E), 32'h0);
        check({tag, "_busy"}, 32'(BUSY), 32'h0);
        check({tag, "_done"}, 32'(DONE), 32'h0);
        check({tag, "_load"}, 32'(AC_LOAD), 32'h0);
    endtask

    task automatic do_op(input logic [3:0] op, input logic [W-1:0] ac, input logic [W-1:0] dr,
                         input bit poke);
        logic [W-1:0]   er;
        logic           ee, el;
        logic [2*W-1:0] pr;
        int             n, lat;
        er = model_r; ee = model_e; el = 1'b1; lat = 0;
        case (op)
            4'h0: er = '0;
            4'h1: er = ac & dr;
            4'h2: {ee, er} = (W+1)'(ac) + (W+1)'(dr);
            4'h3: er = dr;
            4'h4: er = ~ac;
            4'h5: begin ee = !model_e; el = 1'b0; end
            4'h6: begin er = (ac >> 1) | (W'(model_e) << (W-1)); ee = ac[0]; end
            4'h7: begin er = (ac << 1) | W'(model_e); ee = ac[W-1]; end
            4'h8: er = ac + W'(1);
            4'h9: begin ee = 1'b0; el = 1'b0; end
            4'hA: if (MUL_EN) begin
                pr = (2*W)'(ac) * (2*W)'(dr);
                er = pr[W-1:0];
                ee = pr[2*W-1:W] != 0;
                lat = W + 1;
            end else el = 1'b0;
            default: el = 1'b0;
        endcase
        START = 1'b1; OP = op; AC_IN = ac; DR_IN = dr;
        @(posedge clk);
        #1 START = 1'b0; AC_IN = W'($urandom); DR_IN = W'($urandom);
        n = 0;
        @(negedge clk);
        while (!DONE && n < 60) begin
            if (AC_LOAD) check("load_outside_fin", 32'(AC_LOAD), 32'h0);
            if (!BUSY) check("busy_during_op", 32'(BUSY), 32'h1);
            START = poke && n == 3;
            OP = 4'h2;
            n++;
            @(negedge clk);
        end
        START = 1'b0;
        check($sformatf("lat_op%0h", op), 32'(n), 32'(lat));
        check($sformatf("done_op%0h", op), 32'(DONE), 32'h1);
        check($sformatf("busy_op%0h", op), 32'(BUSY), 32'h1);
        check($sformatf("load_op%0h", op), 32'(AC_LOAD), 32'(el));
        check($sformatf("result_op%0h", op), 32'(RESULT), 32'(er));
        check($sformatf("e_op%0h", op), 32'(E), 32'(ee));
        model_r = er; model_e = ee;
        @(negedge clk);
        check($sformatf("done_drop_op%0h", op), 32'(DONE), 32'h0);
        check($sformatf("load_drop_op%0h", op), 32'(AC_LOAD), 32'h0);
    endtask

    initial begin
        #1 check_idle_zero("reset");
        @(negedge clk) REST = 1'b0;
        do_op(4'h3, 16'h0000, 16'h1234, 1'b0);
        do_op(4'h2, 16'hFFFF, 16'hFFFF, 1'b0);
        @(posedge clk);
        #3 REST = 1'b1;
        #1 check_idle_zero("async_reset");
        model_r = '0; model_e = 1'b0;
        @(negedge clk) REST = 1'b0;
        do_op(4'h2, 16'hFFFF, 16'h0001, 1'b0);
        do_op(4'h6, 16'h8001, 16'h0000, 1'b0);
        do_op(4'h9, 16'h0000, 16'h0000, 1'b0);
        do_op(4'h7, 16'h8001, 16'h0000, 1'b0);
        do_op(4'h9, 16'h0000, 16'h0000, 1'b0);
        do_op(4'h8, 16'hFFFF, 16'h0000, 1'b0);
        do_op(4'h5, 16'h0000, 16'h0000, 1'b0);
        do_op(4'h8, 16'hFFFF, 16'h0000, 1'b0);
        do_op(4'h9, 16'h0000, 16'h0000, 1'b0);
        do_op(4'hA, 16'h0123, 16'h0045, 1'b1);
        do_op(4'hA, 16'h1000, 16'h0010, 1'b0);
        do_op(4'hF, 16'h5555, 16'hAAAA, 1'b0);
        if (MUL_EN) begin
            START = 1'b1; OP = 4'hA; AC_IN = 16'h00FF; DR_IN = 16'h00FF;
            @(posedge clk);
            #1 START = 1'b0;
            repeat (8) @(posedge clk);
            #2 REST = 1'b1;
            #1 check_idle_zero("abort");
            model_r = '0; model_e = 1'b0;
            @(negedge clk) REST = 1'b0;
            check("abort_no_load", 32'(AC_LOAD), 32'h0);
            do_op(4'h0, 16'h1111, 16'h2222, 1'b0);
        end
        for (int i = 0; i < 60; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            do_op(op, ($urandom_range(0, 1) != 0) ? model_r : W'($urandom), W'($urandom),
                  ($urandom_range(0, 3) == 0));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ac_alu.md
Name: ac_alu

Overview:
Sequential arithmetic/logic unit directly upstream of the accumulator register.
- Takes the current accumulator value and the data-register operand, and computes the next accumulator value.
- Drives the accumulator's data input and load strobe.
- Owns the E (carry/extend) flip-flop.
- Single-cycle register-reference and memory-reference ops complete in one cycle; multiply runs as a multi-cycle shift-add.

Parameters:
WIDTH, 16, data width of AC_IN, DR_IN, RESULT

Ports:
clk      in   1      system clock, rising edge
REST     in   1      reset, asynchronous, active-high
START    in   1      op request; sampled only in IDLE
OP       in   4      opcode, sampled with START
AC_IN    in   WIDTH  current accumulator value (accumulator DATA_OUT)
DR_IN    in   WIDTH  data-register operand
RESULT   out  WIDTH  next accumulator value (to accumulator DATA_IN), registered
AC_LOAD  out  1      one-cycle accumulator load strobe (to accumulator LOAD)
E        out  1      extend/carry flip-flop
BUSY     out  1      high while state is not IDLE
DONE     out  1      one-cycle completion pulse, every accepted op

Behaviour:
- Reset is asynchronous:
  - RESULT=0, AC_LOAD=0, E=0, BUSY=0, DONE=0.
  - State=IDLE; multiply registers and counter cleared.
  - Reset mid-multiply aborts it; no AC_LOAD is issued.
- States: IDLE, MUL, FIN.
- IDLE, START=1 at edge T: AC_IN, DR_IN and OP are captured.
  - Non-MUL op: RESULT/E/load-flag are computed and registered at T; state -> FIN.
  - MUL: state -> MUL.
- FIN lasts exactly one cycle:
  - DONE=1, BUSY=1, AC_LOAD = load-flag.
  - Returns to IDLE on the next edge.
  - Latency for non-MUL ops: strobe visible in the cycle after the accepting edge.
- START while BUSY (MUL or FIN) is ignored, not queued.
- Opcodes (r = RESULT, ld = AC_LOAD in FIN):
  - 0 CLA: r=0, ld=1.
  - 1 AND: r=AC&DR, ld=1.
  - 2 ADD: {E,r}=AC+DR (WIDTH+1 bits), ld=1.
  - 3 LDA: r=DR, ld=1.
  - 4 CMA: r=~AC, ld=1.
  - 5 CME: E=~E, r unchanged, ld=0.
  - 6 CIR: r={E,AC[W-1:1]}, E=AC[0], ld=1.
  - 7 CIL: r={AC[W-2:0],E}, E=AC[W-1], ld=1.
  - 8 INC: r=AC+1 modulo 2^W, E unchanged (0xFFFF+1 -> 0x0000, E kept), ld=1.
  - 9 CLE: E=0, r unchanged, ld=0.
  - A MUL: see below.
  - B-F: illegal. DONE pulses, ld=0, r and E unchanged.
- MUL (unsigned, AC x DR):
  - Product register P[2W-1:0] is loaded as {0, DR}; multiplicand M=AC; counter=0.
  - Each MUL cycle: if P[0], the upper half becomes P[2W-1:W]+M with carry kept. P is then shifted right one bit, carry entering the top.
  - After exactly WIDTH iterations (edges T+1..T+WIDTH): r=P[W-1:0], E = OR of P[2W-1:W] (overflow); state -> FIN.
  - AC_LOAD/DONE high in the cycle after edge T+WIDTH+1. Total latency WIDTH+2 cycles from START edge to strobe end.
  - BUSY high from the cycle after T through FIN.
- RESULT holds its value between ops. AC_LOAD is never high outside FIN.

Optional Feature:
- Macro: AC_ALU_MUL_EN.
- Defined: opcode A performs the multi-cycle multiply above; MUL state, P register and counter are present.
- Not defined:
  - No MUL state or multiply datapath is synthesized.
  - Opcode A is treated as illegal: FIN after one cycle, DONE=1, AC_LOAD=0, RESULT and E unchanged.

Test Plan:
- Reset then ADD: assert REST mid-cycle -> all outputs 0 immediately; AC_IN=0xFFFF, DR_IN=0x0001, START op 2 -> next cycle RESULT=0x0000, E=1, AC_LOAD=1, DONE=1 for exactly one cycle.
- Rotate pair: E=1, AC_IN=0x8001, CIR -> RESULT=0xC000, E=1. Then AC_IN=0x8001 with E=0, CIL -> RESULT=0x0002, E=1.
- INC wrap and flag ops: AC_IN=0xFFFF, E=0, INC -> RESULT=0x0000, E=0, AC_LOAD=1. CME -> E=1, AC_LOAD=0, DONE=1. CLE -> E=0.
- MUL (macro defined): AC_IN=0x0123, DR_IN=0x0045, START op A -> BUSY high 17 cycles, then RESULT=0x4E6F, E=0, AC_LOAD at cycle 17 after accept. AC_IN=0x1000, DR_IN=0x0010 -> RESULT=0x0000, E=1.
- Busy/abort: START op 2 asserted during MUL -> ignored, no extra DONE. REST asserted at MUL iteration 8 -> IDLE, no AC_LOAD. New CLA accepted the cycle after REST deasserts.
- Illegal and macro-off: op 0xF -> DONE pulse, AC_LOAD=0, RESULT/E unchanged. With AC_ALU_MUL_EN undefined, op A -> DONE one cycle after accept, AC_LOAD=0.
